// File: rtl/rty_pkg.sv
// rty_pkg: definitions shared by the RetryEngine ingress arbiter, RetryEngine
// and their benches.
//   SRC_NUM_D / SRC_NODE_W_D / PAYLD_W / QOS_W : default port geometry
//   rty_req_t : one request as presented to RetryEngine
package rty_pkg;

   localparam int SRC_NUM_D    = 4;
   localparam int SRC_NODE_W_D = 2;
   localparam int PAYLD_W      = 64;
   localparam int QOS_W        = 4;

   typedef struct packed {
      logic                    req_type;
      logic [QOS_W-1:0]        qos;
      logic [SRC_NODE_W_D-1:0] src_id;
      logic [PAYLD_W-1:0]      payload;
   } rty_req_t;

endpackage

// File: rtl/rty_qos_rr_pick.sv
// rty_qos_rr_pick: combinational winner selection among requesting sources.
//   vld    : per-source request valid
//   boost  : per-source promotion flag (outranks any QoS)
//   qos    : per-source QoS, source i at [i*QW +: QW]
//   rr_ptr : first source examined when breaking ties
//   winner : index of the selected source (0 when none)
//   any    : at least one source is requesting
module rty_qos_rr_pick
   import rty_pkg::*;
#(
   parameter int N  = SRC_NUM_D,
   parameter int W  = SRC_NODE_W_D,
   parameter int QW = QOS_W
) (
   input  logic [N-1:0]    vld,
   input  logic [N-1:0]    boost,
   input  logic [N*QW-1:0] qos,
   input  logic [W-1:0]    rr_ptr,
   output logic [W-1:0]    winner,
   output logic            any
);

   logic [QW:0] best_key;
   logic [QW:0] key;
   int          idx;

   // Walk the sources in round-robin order from rr_ptr; only a strictly
   // larger {boost, qos} key displaces the current pick, so among equal keys
   // the first one met in rotation order wins.
   always_comb begin
      winner   = '0;
      any      = 1'b0;
      best_key = '0;
      key      = '0;
      idx      = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N) idx = idx - N;
         key = {boost[idx], qos[idx*QW +: QW]};
         if (vld[idx] && (!any || key > best_key)) begin
            any      = 1'b1;
            best_key = key;
            winner   = W'(idx);
         end
      end
   end

endmodule

// File: rtl/rty_req_arbiter.sv
// rty_req_arbiter: merges SRC_NUM source request ports into the single
// RetryEngine request port and routes RetryEngine grants back to sources.
// A granted source's next request is promoted (wins arbitration and is
// issued as req_type=0).
//   clk, rst_n                     : clock, async active-low reset
//   src_vld/src_rdy                : per-source request handshake
//   src_retry_ok/src_qos/src_payload : per-source request attributes
//   src_grant                      : one-cycle grant pulse per source
//   vld_req_in/rdy_req_in          : handshake toward RetryEngine
//   req_type/qos_type/src_id/payload_in : registered request toward RetryEngine
//   vld_out_grant/rdy_out_grant/grant_des_id : grant channel from RetryEngine
module rty_req_arbiter
   import rty_pkg::*;
#(
   parameter int SRC_NUM    = SRC_NUM_D,
   parameter int SRC_NODE_W = SRC_NODE_W_D,
   parameter int PAYLD_BW   = PAYLD_W,
   parameter int QoS_CLASS  = QOS_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [SRC_NUM-1:0]      src_vld,
   output logic [SRC_NUM-1:0]      src_rdy,
   input  logic [SRC_NUM-1:0]      src_retry_ok,
   input  logic [SRC_NUM*QoS_CLASS-1:0] src_qos,
   input  logic [SRC_NUM*PAYLD_BW-1:0]  src_payload,
   output logic [SRC_NUM-1:0]      src_grant,
   output logic                    vld_req_in,
   input  logic                    rdy_req_in,
   output logic                    req_type,
   output logic [QoS_CLASS-1:0]    qos_type,
   output logic [SRC_NODE_W-1:0]   src_id,
   output logic [PAYLD_BW-1:0]     payload_in,
   input  logic                    vld_out_grant,
   output logic                    rdy_out_grant,
   input  logic [SRC_NODE_W-1:0]   grant_des_id
);

   logic [SRC_NUM-1:0]    granted;
   logic [SRC_NUM-1:0]    win_oh;
   logic [SRC_NUM-1:0]    grant_match;
   logic [SRC_NUM-1:0]    grant_set;
   logic [SRC_NODE_W-1:0] rr_ptr;
   logic [SRC_NODE_W-1:0] winner;
   logic                  pick_any;
   logic                  load_en;
   logic                  xfer;

   rty_qos_rr_pick #(
      .N  (SRC_NUM),
      .W  (SRC_NODE_W),
      .QW (QoS_CLASS)
   ) u_pick (
      .vld    (src_vld),
      .boost  (granted),
      .qos    (src_qos),
      .rr_ptr (rr_ptr),
      .winner (winner),
      .any    (pick_any)
   );

   // grant_match is empty for ids >= SRC_NUM, which makes such grants
   // always acceptable and then silently dropped.
   always_comb begin
      win_oh      = '0;
      grant_match = '0;
      for (int i = 0; i < SRC_NUM; i++) begin
         win_oh[i]      = (winner == SRC_NODE_W'(i));
         grant_match[i] = (grant_des_id == SRC_NODE_W'(i));
      end
   end

   assign load_en       = !vld_req_in || rdy_req_in;
   assign xfer          = rst_n && load_en && pick_any;
   assign src_rdy       = {SRC_NUM{xfer}} & win_oh;
   assign rdy_out_grant = ~|(grant_match & granted);
   assign grant_set     = {SRC_NUM{vld_out_grant && rdy_out_grant}} & grant_match;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_req_in <= 1'b0;
         req_type   <= 1'b0;
         qos_type   <= '0;
         src_id     <= '0;
         payload_in <= '0;
         src_grant  <= '0;
         granted    <= '0;
         rr_ptr     <= '0;
      end else begin
         src_grant <= grant_set;
         // Set is applied after clear: a grant landing in the same cycle as
         // that source's transfer promotes the following request.
         granted   <= (granted & ~src_rdy) | grant_set;
         if (load_en) begin
            vld_req_in <= pick_any;
            if (pick_any) begin
               req_type   <= (|(granted & win_oh)) ? 1'b0 : |(src_retry_ok & win_oh);
               qos_type   <= src_qos[int'(winner)*QoS_CLASS +: QoS_CLASS];
               src_id     <= winner;
               payload_in <= src_payload[int'(winner)*PAYLD_BW +: PAYLD_BW];
               rr_ptr     <= (winner == SRC_NODE_W'(SRC_NUM-1)) ? '0 : winner + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rty_req_arbiter.sv
module tb_rty_req_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   // 4-source instance
   logic [3:0]   src_vld, src_rdy, src_retry_ok, src_grant;
   logic [15:0]  src_qos;
   logic [255:0] src_payload;
   logic         vld_req_in, rdy_req_in, req_type;
   logic [3:0]   qos_type;
   logic [1:0]   src_id;
   logic [63:0]  payload_in;
   logic         vld_out_grant, rdy_out_grant;
   logic [1:0]   grant_des_id;

   // 3-source instance
   logic [2:0]   t3_vld, t3_rdy, t3_retry_ok, t3_grant;
   logic [11:0]  t3_qos;
   logic [191:0] t3_payload;
   logic         t3_vld_req, t3_rdy_req, t3_req_type;
   logic [3:0]   t3_qos_type;
   logic [1:0]   t3_src_id;
   logic [63:0]  t3_payload_in;
   logic         t3_vld_og, t3_rdy_og;
   logic [1:0]   t3_gid;

   int n_checks = 0;
   int n_errors = 0;

   rty_req_arbiter #(.SRC_NUM(4), .SRC_NODE_W(2), .PAYLD_BW(64), .QoS_CLASS(4)) dut (
      .clk(clk), .rst_n(rst_n), .src_vld(src_vld), .src_rdy(src_rdy),
      .src_retry_ok(src_retry_ok), .src_qos(src_qos), .src_payload(src_payload),
      .src_grant(src_grant), .vld_req_in(vld_req_in), .rdy_req_in(rdy_req_in),
      .req_type(req_type), .qos_type(qos_type), .src_id(src_id), .payload_in(payload_in),
      .vld_out_grant(vld_out_grant), .rdy_out_grant(rdy_out_grant), .grant_des_id(grant_des_id));

   rty_req_arbiter #(.SRC_NUM(3), .SRC_NODE_W(2), .PAYLD_BW(64), .QoS_CLASS(4)) dut3 (
      .clk(clk), .rst_n(rst_n), .src_vld(t3_vld), .src_rdy(t3_rdy),
      .src_retry_ok(t3_retry_ok), .src_qos(t3_qos), .src_payload(t3_payload),
      .src_grant(t3_grant), .vld_req_in(t3_vld_req), .rdy_req_in(t3_rdy_req),
      .req_type(t3_req_type), .qos_type(t3_qos_type), .src_id(t3_src_id),
      .payload_in(t3_payload_in), .vld_out_grant(t3_vld_og), .rdy_out_grant(t3_rdy_og),
      .grant_des_id(t3_gid));

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      src_vld = '0; src_retry_ok = '0; src_qos = '0; src_payload = '0;
      rdy_req_in = 1'b1; vld_out_grant = 1'b0; grant_des_id = '0;
      t3_vld = '0; t3_retry_ok = '0; t3_qos = '0; t3_payload = '0;
      t3_rdy_req = 1'b1; t3_vld_og = 1'b0; t3_gid = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic set_src(input int i, input logic v, input logic [3:0] q,
                          input logic ok, input logic [63:0] p);
      src_vld[i] = v;
      src_qos[i*4 +: 4] = q;
      src_retry_ok[i] = ok;
      src_payload[i*64 +: 64] = p;
   endtask

   // Reference pick: best {granted, qos}, ties to smallest rotational
   // distance from the round-robin pointer. Returns -1 if nothing valid.
   function automatic int model_pick(input logic [3:0] v, input logic [15:0] q,
                                     input logic [3:0] g, input int rr);
      int best, best_key, best_dist, k, d;
      best = -1; best_key = -1; best_dist = 99;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) begin
            k = (g[i] ? 16 : 0) + int'(q[i*4 +: 4]);
            d = (i - rr + 4) % 4;
            if (k > best_key || (k == best_key && d < best_dist)) begin
               best = i; best_key = k; best_dist = d;
            end
         end
      end
      return best;
   endfunction

   task automatic test_reset();
      idle_inputs();
      src_vld = 4'hF;
      rst_n = 1'b0;
      #12;
      n_checks++; if (vld_req_in !== 1'b0) begin n_errors++; $display("FAIL reset_vld: got %0b want 0", vld_req_in); end
      n_checks++; if ({req_type, qos_type, src_id} !== 7'd0) begin n_errors++; $display("FAIL reset_fields: got %0h want 0", {req_type, qos_type, src_id}); end
      n_checks++; if (payload_in !== 64'd0) begin n_errors++; $display("FAIL reset_payload: got %0h want 0", payload_in); end
      n_checks++; if (src_grant !== 4'd0) begin n_errors++; $display("FAIL reset_src_grant: got %0h want 0", src_grant); end
      n_checks++; if (src_rdy !== 4'd0) begin n_errors++; $display("FAIL reset_src_rdy: got %0h want 0", src_rdy); end
      n_checks++; if (rdy_out_grant !== 1'b1) begin n_errors++; $display("FAIL reset_rdy_out_grant: got %0b want 1", rdy_out_grant); end
      src_vld = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      set_src(2, 1'b1, 4'd5, 1'b1, 64'hCAFE_0000_0000_0002);
      rdy_req_in = 1'b1;
      settle();
      n_checks++; if (src_rdy !== 4'b0100) begin n_errors++; $display("FAIL single_src_rdy: got %0h want 4", src_rdy); end
      tick();
      src_vld = '0;
      settle();
      n_checks++; if (vld_req_in !== 1'b1) begin n_errors++; $display("FAIL single_vld: got %0b want 1", vld_req_in); end
      n_checks++; if (src_id !== 2'd2) begin n_errors++; $display("FAIL single_src_id: got %0d want 2", src_id); end
      n_checks++; if (qos_type !== 4'd5) begin n_errors++; $display("FAIL single_qos: got %0d want 5", qos_type); end
      n_checks++; if (req_type !== 1'b1) begin n_errors++; $display("FAIL single_req_type: got %0b want 1", req_type); end
      n_checks++; if (payload_in !== 64'hCAFE_0000_0000_0002) begin n_errors++; $display("FAIL single_payload: got %0h", payload_in); end
      tick();
      n_checks++; if (vld_req_in !== 1'b0) begin n_errors++; $display("FAIL single_vld_drop: got %0b want 0", vld_req_in); end
   endtask

   // rr_ptr is 3 here (last issue came from source 2)
   task automatic test_backpressure();
      set_src(0, 1'b1, 4'd0, 1'b0, 64'h1111_0000);
      set_src(1, 1'b1, 4'd0, 1'b1, 64'h2222_0001);
      rdy_req_in = 1'b0;
      settle();
      n_checks++; if (src_rdy !== 4'b0001) begin n_errors++; $display("FAIL bp_first_rdy: got %0h want 1", src_rdy); end
      tick();
      src_payload[63:0] = 64'h3333_0000;
      for (int c = 0; c < 3; c++) begin
         settle();
         n_checks++; if (src_rdy !== 4'b0000) begin n_errors++; $display("FAIL bp_hold_rdy[%0d]: got %0h want 0", c, src_rdy); end
         n_checks++; if ({vld_req_in, src_id} !== 3'b1_00 || payload_in !== 64'h1111_0000) begin
            n_errors++; $display("FAIL bp_hold_out[%0d]: got vld=%0b id=%0d pay=%0h", c, vld_req_in, src_id, payload_in);
         end
         tick();
      end
      rdy_req_in = 1'b1;
      settle();
      n_checks++; if (src_rdy !== 4'b0010) begin n_errors++; $display("FAIL bp_release_rdy: got %0h want 2", src_rdy); end
      tick();
      src_vld = '0;
      settle();
      n_checks++; if (src_id !== 2'd1 || payload_in !== 64'h2222_0001) begin n_errors++; $display("FAIL bp_second: got id=%0d pay=%0h", src_id, payload_in); end
      tick();
   endtask

   task automatic test_qos();
      set_src(0, 1'b1, 4'd1, 1'b0, 64'hA0);
      set_src(3, 1'b1, 4'd9, 1'b1, 64'hA3);
      settle();
      n_checks++; if (src_rdy !== 4'b1000) begin n_errors++; $display("FAIL qos_first_rdy: got %0h want 8", src_rdy); end
      tick();
      src_vld[3] = 1'b0;
      settle();
      n_checks++; if (src_id !== 2'd3 || qos_type !== 4'd9) begin n_errors++; $display("FAIL qos_first: got id=%0d qos=%0d want 3/9", src_id, qos_type); end
      n_checks++; if (src_rdy !== 4'b0001) begin n_errors++; $display("FAIL qos_second_rdy: got %0h want 1", src_rdy); end
      tick();
      src_vld = '0;
      settle();
      n_checks++; if (src_id !== 2'd0 || qos_type !== 4'd1 || req_type !== 1'b0) begin
         n_errors++; $display("FAIL qos_second: got id=%0d qos=%0d type=%0b want 0/1/0", src_id, qos_type, req_type);
      end
      tick();
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int i = 0; i < 4; i++) set_src(i, 1'b1, 4'd3, 1'b1, 64'(i + 16));
      for (int k = 0; k < 5; k++) begin
         settle();
         n_checks++; if (src_rdy !== 4'(1 << (k % 4))) begin n_errors++; $display("FAIL rr_rdy[%0d]: got %0h want %0h", k, src_rdy, 4'(1 << (k % 4))); end
         tick();
         n_checks++; if (src_id !== 2'(k % 4)) begin n_errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, src_id, k % 4); end
      end
      src_vld = '0;
      tick();
   endtask

   task automatic test_grant_promotion();
      apply_reset();
      vld_out_grant = 1'b1; grant_des_id = 2'd1;
      settle();
      n_checks++; if (rdy_out_grant !== 1'b1) begin n_errors++; $display("FAIL gp_accept: got %0b want 1", rdy_out_grant); end
      tick();
      vld_out_grant = 1'b0;
      settle();
      n_checks++; if (src_grant !== 4'b0010) begin n_errors++; $display("FAIL gp_pulse: got %0h want 2", src_grant); end
      tick();
      n_checks++; if (src_grant !== 4'b0000) begin n_errors++; $display("FAIL gp_pulse_end: got %0h want 0", src_grant); end
      vld_out_grant = 1'b1; grant_des_id = 2'd1;
      set_src(1, 1'b1, 4'd0, 1'b1, 64'hB1);
      set_src(2, 1'b1, 4'd15, 1'b1, 64'hB2);
      settle();
      n_checks++; if (rdy_out_grant !== 1'b0) begin n_errors++; $display("FAIL gp_second_blocked: got %0b want 0", rdy_out_grant); end
      n_checks++; if (src_rdy !== 4'b0010) begin n_errors++; $display("FAIL gp_boost_rdy: got %0h want 2", src_rdy); end
      tick();
      vld_out_grant = 1'b0;
      src_vld[1] = 1'b0;
      settle();
      n_checks++; if ({vld_req_in, src_id, req_type} !== 4'b1_01_0) begin
         n_errors++; $display("FAIL gp_issue: got vld=%0b id=%0d type=%0b want 1/1/0", vld_req_in, src_id, req_type);
      end
      n_checks++; if (rdy_out_grant !== 1'b1) begin n_errors++; $display("FAIL gp_flag_cleared: got %0b want 1", rdy_out_grant); end
      n_checks++; if (src_rdy !== 4'b0100) begin n_errors++; $display("FAIL gp_next_rdy: got %0h want 4", src_rdy); end
      tick();
      src_vld = '0;
      settle();
      n_checks++; if (src_id !== 2'd2 || req_type !== 1'b1 || src_grant !== 4'd0) begin
         n_errors++; $display("FAIL gp_after: got id=%0d type=%0b grant=%0h want 2/1/0", src_id, req_type, src_grant);
      end
      tick();
   endtask

   task automatic test_three_sources();
      apply_reset();
      t3_vld = 3'b111; t3_qos = {3{4'd2}}; t3_rdy_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++; if (t3_src_id !== 2'(k % 3)) begin n_errors++; $display("FAIL n3_rr[%0d]: got %0d want %0d", k, t3_src_id, k % 3); end
      end
      t3_vld = '0;
      t3_vld_og = 1'b1; t3_gid = 2'd3;
      settle();
      n_checks++; if (t3_rdy_og !== 1'b1) begin n_errors++; $display("FAIL n3_bad_id_rdy: got %0b want 1", t3_rdy_og); end
      tick();
      n_checks++; if (t3_grant !== 3'd0) begin n_errors++; $display("FAIL n3_bad_id_pulse: got %0h want 0", t3_grant); end
      n_checks++; if (t3_rdy_og !== 1'b1) begin n_errors++; $display("FAIL n3_bad_id_still_rdy: got %0b want 1", t3_rdy_og); end
      t3_gid = 2'd2;
      tick();
      t3_vld_og = 1'b0;
      n_checks++; if (t3_grant !== 3'b100) begin n_errors++; $display("FAIL n3_id2_pulse: got %0h want 4", t3_grant); end
      tick();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      vld_out_grant = 1'b1; grant_des_id = 2'd2;
      set_src(0, 1'b1, 4'd4, 1'b1, 64'hD0);
      rdy_req_in = 1'b0;
      tick();
      vld_out_grant = 1'b0;
      settle();
      n_checks++; if (vld_req_in !== 1'b1 || rdy_out_grant !== 1'b0) begin
         n_errors++; $display("FAIL rm_setup: got vld=%0b rdy_og=%0b want 1/0", vld_req_in, rdy_out_grant);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (vld_req_in !== 1'b0) begin n_errors++; $display("FAIL rm_vld: got %0b want 0", vld_req_in); end
      n_checks++; if (rdy_out_grant !== 1'b1) begin n_errors++; $display("FAIL rm_granted_cleared: got %0b want 1", rdy_out_grant); end
      n_checks++; if (src_rdy !== 4'd0 || src_grant !== 4'd0) begin n_errors++; $display("FAIL rm_rdy_grant: got rdy=%0h grant=%0h want 0/0", src_rdy, src_grant); end
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_random();
      logic        m_vld, m_type;
      logic [3:0]  m_qos, m_granted, m_pulse;
      logic [1:0]  m_id;
      logic [63:0] m_pay;
      int          m_rr, w;
      logic        load, e_rog;
      logic [3:0]  e_rdy;
      apply_reset();
      m_vld = 0; m_type = 0; m_qos = 0; m_id = 0; m_pay = 0;
      m_granted = 0; m_pulse = 0; m_rr = 0;
      for (int c = 0; c < 400; c++) begin
         src_vld = 4'($urandom_range(0, 15));
         src_retry_ok = 4'($urandom_range(0, 15));
         for (int i = 0; i < 4; i++) begin
            src_qos[i*4 +: 4] = 4'($urandom_range(0, 3));
            src_payload[i*64 +: 64] = {$urandom(), $urandom()};
         end
         rdy_req_in = ($urandom_range(0, 3) != 0);
         vld_out_grant = ($urandom_range(0, 3) == 0);
         grant_des_id = 2'($urandom_range(0, 3));
         settle();
         load = !m_vld || rdy_req_in;
         w = model_pick(src_vld, src_qos, m_granted, m_rr);
         e_rdy = (load && w >= 0) ? 4'(1 << w) : 4'd0;
         e_rog = !m_granted[grant_des_id];
         n_checks++; if (src_rdy !== e_rdy) begin n_errors++; $display("FAIL rnd_src_rdy[%0d]: got %0h want %0h", c, src_rdy, e_rdy); end
         n_checks++; if (rdy_out_grant !== e_rog) begin n_errors++; $display("FAIL rnd_rdy_og[%0d]: got %0b want %0b", c, rdy_out_grant, e_rog); end
         n_checks++; if (src_grant !== m_pulse) begin n_errors++; $display("FAIL rnd_src_grant[%0d]: got %0h want %0h", c, src_grant, m_pulse); end
         n_checks++; if (vld_req_in !== m_vld) begin n_errors++; $display("FAIL rnd_vld[%0d]: got %0b want %0b", c, vld_req_in, m_vld); end
         if (m_vld) begin
            n_checks++; if ({req_type, qos_type, src_id} !== {m_type, m_qos, m_id} || payload_in !== m_pay) begin
               n_errors++; $display("FAIL rnd_req[%0d]: got type=%0b qos=%0d id=%0d pay=%0h want %0b/%0d/%0d/%0h",
                                    c, req_type, qos_type, src_id, payload_in, m_type, m_qos, m_id, m_pay);
            end
         end
         m_pulse = '0;
         if (load) begin
            m_vld = (w >= 0);
            if (w >= 0) begin
               m_type = m_granted[w] ? 1'b0 : src_retry_ok[w];
               m_qos = src_qos[w*4 +: 4];
               m_id = 2'(w);
               m_pay = src_payload[w*64 +: 64];
               m_rr = (w + 1) % 4;
               m_granted[w] = 1'b0;
            end
         end
         if (vld_out_grant && e_rog) begin
            m_granted[grant_des_id] = 1'b1;
            m_pulse[grant_des_id] = 1'b1;
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      test_reset();
      test_single();
      test_backpressure();
      test_qos();
      test_round_robin();
      test_grant_promotion();
      test_three_sources();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
